// File: rtl/hash_row_pe_dispatcher_pkg.sv
// Shared widths, FSM encodings and job helpers for the hash row PE dispatcher.
// The optional perf counters are controlled by HASH_DISPATCH_PERF_CNT_EN in the top.
package hash_row_pe_dispatcher_pkg;

  localparam int HASH_ISSUE_WIDTH      = 4;
  localparam int HASH_ISSUE_WIDTH_LOG2 = 2;
  localparam int ADDR_WIDTH            = 16;
  localparam int META_MATCH_LEN_WIDTH  = 5;
  localparam int JOB_W = 2*ADDR_WIDTH + META_MATCH_LEN_WIDTH + 1 + 8;

  localparam logic [1:0] DISP_S_IDLE  = 2'd0;
  localparam logic [1:0] DISP_S_ISSUE = 2'd1;
  localparam logic [1:0] DISP_S_DRAIN = 2'd2;

  localparam logic [HASH_ISSUE_WIDTH-1:0] SLOT_ONE = HASH_ISSUE_WIDTH'(1);

  typedef logic [HASH_ISSUE_WIDTH_LOG2-1:0] slot_idx_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]           head_addr;
    logic [ADDR_WIDTH-1:0]           history_addr;
    logic [META_MATCH_LEN_WIDTH-1:0] meta_match_len;
    logic                            meta_match_can_ext;
    logic [7:0]                      data;
  } job_t;

  function automatic slot_idx_t lowest_slot(input logic [HASH_ISSUE_WIDTH-1:0] mask);
    lowest_slot = '0;
    for (int i = HASH_ISSUE_WIDTH-1; i >= 0; i--) begin
      if (mask[i]) lowest_slot = slot_idx_t'(i);
    end
  endfunction

  // Slot head address wraps modulo 2^ADDR_WIDTH by construction.
  function automatic job_t build_job(
    input logic [ADDR_WIDTH-1:0]                            head,
    input logic [HASH_ISSUE_WIDTH*ADDR_WIDTH-1:0]           hist,
    input logic [HASH_ISSUE_WIDTH*META_MATCH_LEN_WIDTH-1:0] meta,
    input logic [HASH_ISSUE_WIDTH-1:0]                      can_ext,
    input logic [HASH_ISSUE_WIDTH*8-1:0]                    data,
    input slot_idx_t                                        slot
  );
    job_t j;
    j.head_addr          = head + ADDR_WIDTH'(slot);
    j.history_addr       = hist[slot*ADDR_WIDTH +: ADDR_WIDTH];
    j.meta_match_len     = meta[slot*META_MATCH_LEN_WIDTH +: META_MATCH_LEN_WIDTH];
    j.meta_match_can_ext = can_ext[slot];
    j.data               = data[slot*8 +: 8];
    return j;
  endfunction

endpackage

// File: rtl/hash_row_pe_dispatcher_rr_pick.sv
// Combinational round-robin picker: first set bit of ready searching cyclically from ptr.
// When nothing is ready, found=0 and idx=ptr.
module hash_row_pe_dispatcher_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     ready,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0] cand;

  // Walk offsets from the far end so the nearest ready index wins last.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = '0;
    for (int i = N-1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (ready[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/hash_row_pe_dispatcher.sv
// Serializes valid history slots of a hash row into single-candidate jobs, round-robin over
// NUM_PE match PEs, and drains on delimited rows. Optional macro: HASH_DISPATCH_PERF_CNT_EN.
module hash_row_pe_dispatcher
  import hash_row_pe_dispatcher_pkg::*;
#(
  parameter int NUM_PE      = 4,
  parameter int NUM_PE_LOG2 = 2
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            row_valid,
  input  logic [ADDR_WIDTH-1:0]                           row_head_addr,
  input  logic [HASH_ISSUE_WIDTH-1:0]                     row_history_valid,
  input  logic [HASH_ISSUE_WIDTH*ADDR_WIDTH-1:0]           row_history_addr,
  input  logic [HASH_ISSUE_WIDTH*META_MATCH_LEN_WIDTH-1:0] row_meta_match_len,
  input  logic [HASH_ISSUE_WIDTH-1:0]                     row_meta_match_can_ext,
  input  logic [HASH_ISSUE_WIDTH*8-1:0]                   row_data,
  input  logic                                            row_delim,
  output logic                                            row_ready,
  output logic [NUM_PE-1:0]                               job_valid,
  input  logic [NUM_PE-1:0]                               job_ready,
  output logic [ADDR_WIDTH-1:0]                           job_head_addr,
  output logic [ADDR_WIDTH-1:0]                           job_history_addr,
  output logic [META_MATCH_LEN_WIDTH-1:0]                 job_meta_match_len,
  output logic                                            job_meta_match_can_ext,
  output logic [7:0]                                      job_data,
  input  logic [NUM_PE-1:0]                               pe_idle,
  output logic                                            done_valid,
  input  logic                                            done_ready,
  output logic [1:0]                                      dbg_state
`ifdef HASH_DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]                                     perf_stall_cycles,
  output logic [31:0]                                     perf_jobs
`endif
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high.
  // valid, once raised, holds with a stable payload until that transfer; valid never depends
  // combinationally on ready, and ready may change freely.

  logic [1:0]                                      state_q, state_d;
  logic                                            row_ready_q, row_ready_d;
  logic [NUM_PE-1:0]                               job_valid_q, job_valid_d;
  logic [NUM_PE_LOG2-1:0]                          tgt_q, tgt_d;
  logic [NUM_PE_LOG2-1:0]                          rr_ptr_q, rr_ptr_d;
  logic [HASH_ISSUE_WIDTH-1:0]                     mask_q, mask_d;
  slot_idx_t                                       slot_q, slot_d;
  logic                                            delim_q, delim_d;
  logic                                            done_valid_q, done_valid_d;
  logic                                            idle_seen_q, idle_seen_d;
  logic [ADDR_WIDTH-1:0]                           head_q, head_d;
  logic [HASH_ISSUE_WIDTH*ADDR_WIDTH-1:0]           hist_q, hist_d;
  logic [HASH_ISSUE_WIDTH*META_MATCH_LEN_WIDTH-1:0] meta_q, meta_d;
  logic [HASH_ISSUE_WIDTH-1:0]                     can_ext_q, can_ext_d;
  logic [HASH_ISSUE_WIDTH*8-1:0]                   data_q, data_d;
  job_t                                            job_q, job_d;

  logic                        accept;
  logic                        job_hs;
  logic                        done_hs;
  logic                        all_idle;
  logic [NUM_PE_LOG2-1:0]      next_ptr;
  logic [NUM_PE_LOG2-1:0]      pick_ptr;
  logic                        pick_found;
  logic [NUM_PE_LOG2-1:0]      pick_idx;
  logic [NUM_PE_LOG2-1:0]      tgt_sel;
  logic [HASH_ISSUE_WIDTH-1:0] mask_rem;

  assign accept   = row_ready_q & row_valid;
  assign job_hs   = |(job_valid_q & job_ready);
  assign done_hs  = done_valid_q & done_ready;
  assign all_idle = &pe_idle;
  assign next_ptr = (tgt_q == NUM_PE_LOG2'(NUM_PE-1)) ? '0 : tgt_q + 1'b1;
  // A job loaded on the handshake cycle is searched from the post-handshake pointer.
  assign pick_ptr = job_hs ? next_ptr : rr_ptr_q;
  assign tgt_sel  = pick_found ? pick_idx : pick_ptr;
  assign mask_rem = mask_q & ~(SLOT_ONE << slot_q);

  hash_row_pe_dispatcher_rr_pick #(
    .N     (NUM_PE),
    .IDX_W (NUM_PE_LOG2)
  ) u_rr_pick (
    .ready (job_ready),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    job_valid_d  = job_valid_q;
    tgt_d        = tgt_q;
    rr_ptr_d     = rr_ptr_q;
    mask_d       = mask_q;
    slot_d       = slot_q;
    delim_d      = delim_q;
    done_valid_d = done_valid_q;
    idle_seen_d  = 1'b0;
    head_d       = head_q;
    hist_d       = hist_q;
    meta_d       = meta_q;
    can_ext_d    = can_ext_q;
    data_d       = data_q;
    job_d        = job_q;

    case (state_q)
      DISP_S_IDLE: begin
        if (accept) begin
          head_d    = row_head_addr;
          hist_d    = row_history_addr;
          meta_d    = row_meta_match_len;
          can_ext_d = row_meta_match_can_ext;
          data_d    = row_data;
          mask_d    = row_history_valid;
          delim_d   = row_delim;
          if (row_history_valid != '0) begin
            slot_d      = lowest_slot(row_history_valid);
            job_d       = build_job(row_head_addr, row_history_addr, row_meta_match_len,
                                    row_meta_match_can_ext, row_data,
                                    lowest_slot(row_history_valid));
            job_valid_d          = '0;
            job_valid_d[tgt_sel] = 1'b1;
            tgt_d       = tgt_sel;
            state_d     = DISP_S_ISSUE;
          end else if (row_delim) begin
            state_d = DISP_S_DRAIN;
          end
        end
      end
      DISP_S_ISSUE: begin
        if (job_hs) begin
          rr_ptr_d = next_ptr;
          mask_d   = mask_rem;
          if (mask_rem != '0) begin
            slot_d      = lowest_slot(mask_rem);
            job_d       = build_job(head_q, hist_q, meta_q, can_ext_q, data_q,
                                    lowest_slot(mask_rem));
            job_valid_d          = '0;
            job_valid_d[tgt_sel] = 1'b1;
            tgt_d       = tgt_sel;
          end else begin
            job_valid_d = '0;
            state_d     = delim_q ? DISP_S_DRAIN : DISP_S_IDLE;
          end
        end
      end
      DISP_S_DRAIN: begin
        // PEs may still report idle the cycle after taking the last job, so require
        // one full registered cycle of all-idle before signalling done.
        idle_seen_d = all_idle & ~done_hs;
        if (done_hs) begin
          done_valid_d = 1'b0;
          state_d      = DISP_S_IDLE;
        end else if (idle_seen_q && all_idle) begin
          done_valid_d = 1'b1;
        end
      end
      default: begin
        state_d      = DISP_S_IDLE;
        job_valid_d  = '0;
        done_valid_d = 1'b0;
      end
    endcase

    row_ready_d = (state_d == DISP_S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= DISP_S_IDLE;
      row_ready_q  <= 1'b0;
      job_valid_q  <= '0;
      tgt_q        <= '0;
      rr_ptr_q     <= '0;
      mask_q       <= '0;
      slot_q       <= '0;
      delim_q      <= 1'b0;
      done_valid_q <= 1'b0;
      idle_seen_q  <= 1'b0;
      head_q       <= '0;
      hist_q       <= '0;
      meta_q       <= '0;
      can_ext_q    <= '0;
      data_q       <= '0;
      job_q        <= '0;
    end else begin
      state_q      <= state_d;
      row_ready_q  <= row_ready_d;
      job_valid_q  <= job_valid_d;
      tgt_q        <= tgt_d;
      rr_ptr_q     <= rr_ptr_d;
      mask_q       <= mask_d;
      slot_q       <= slot_d;
      delim_q      <= delim_d;
      done_valid_q <= done_valid_d;
      idle_seen_q  <= idle_seen_d;
      head_q       <= head_d;
      hist_q       <= hist_d;
      meta_q       <= meta_d;
      can_ext_q    <= can_ext_d;
      data_q       <= data_d;
      job_q        <= job_d;
    end
  end

  assign row_ready              = row_ready_q;
  assign job_valid              = job_valid_q;
  assign job_head_addr          = job_q.head_addr;
  assign job_history_addr       = job_q.history_addr;
  assign job_meta_match_len     = job_q.meta_match_len;
  assign job_meta_match_can_ext = job_q.meta_match_can_ext;
  assign job_data               = job_q.data;
  assign done_valid             = done_valid_q;
  assign dbg_state              = state_q;

`ifdef HASH_DISPATCH_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_jobs_q, perf_jobs_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_jobs_d  = perf_jobs_q;
    if ((job_valid_q != '0) && !job_hs && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 1'b1;
    if (job_hs && (perf_jobs_q != '1)) perf_jobs_d = perf_jobs_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_jobs_q  <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_jobs_q  <= perf_jobs_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_jobs         = perf_jobs_q;
`endif

endmodule

// File: tb/tb_hash_row_pe_dispatcher.sv
// Self-checking bench for hash_row_pe_dispatcher: directed scenarios plus a job scoreboard.
module tb_hash_row_pe_dispatcher;
  import hash_row_pe_dispatcher_pkg::*;

  localparam int NUM_PE      = 4;
  localparam int NUM_PE_LOG2 = 2;
  localparam int EW          = NUM_PE_LOG2 + JOB_W;

  logic                                            clk;
  logic                                            rst_n;
  logic                                            row_valid;
  logic [ADDR_WIDTH-1:0]                           row_head_addr;
  logic [HASH_ISSUE_WIDTH-1:0]                     row_history_valid;
  logic [HASH_ISSUE_WIDTH*ADDR_WIDTH-1:0]           row_history_addr;
  logic [HASH_ISSUE_WIDTH*META_MATCH_LEN_WIDTH-1:0] row_meta_match_len;
  logic [HASH_ISSUE_WIDTH-1:0]                     row_meta_match_can_ext;
  logic [HASH_ISSUE_WIDTH*8-1:0]                   row_data;
  logic                                            row_delim;
  logic                                            row_ready;
  logic [NUM_PE-1:0]                               job_valid;
  logic [NUM_PE-1:0]                               job_ready;
  logic [ADDR_WIDTH-1:0]                           job_head_addr;
  logic [ADDR_WIDTH-1:0]                           job_history_addr;
  logic [META_MATCH_LEN_WIDTH-1:0]                 job_meta_match_len;
  logic                                            job_meta_match_can_ext;
  logic [7:0]                                      job_data;
  logic [NUM_PE-1:0]                               pe_idle;
  logic                                            done_valid;
  logic                                            done_ready;
  logic [1:0]                                      dbg_state;
`ifdef HASH_DISPATCH_PERF_CNT_EN
  logic [31:0]                                     perf_stall_cycles;
  logic [31:0]                                     perf_jobs;
`endif

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_obs;
  logic [EW-1:0] mon_exp;
  int errors = 0;
  int checks = 0;
  int model_rr = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  hash_row_pe_dispatcher #(
    .NUM_PE      (NUM_PE),
    .NUM_PE_LOG2 (NUM_PE_LOG2)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .row_valid              (row_valid),
    .row_head_addr          (row_head_addr),
    .row_history_valid      (row_history_valid),
    .row_history_addr       (row_history_addr),
    .row_meta_match_len     (row_meta_match_len),
    .row_meta_match_can_ext (row_meta_match_can_ext),
    .row_data               (row_data),
    .row_delim              (row_delim),
    .row_ready              (row_ready),
    .job_valid              (job_valid),
    .job_ready              (job_ready),
    .job_head_addr          (job_head_addr),
    .job_history_addr       (job_history_addr),
    .job_meta_match_len     (job_meta_match_len),
    .job_meta_match_can_ext (job_meta_match_can_ext),
    .job_data               (job_data),
    .pe_idle                (pe_idle),
    .done_valid             (done_valid),
    .done_ready             (done_ready),
    .dbg_state              (dbg_state)
`ifdef HASH_DISPATCH_PERF_CNT_EN
    ,
    .perf_stall_cycles      (perf_stall_cycles),
    .perf_jobs              (perf_jobs)
`endif
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick(input logic [NUM_PE-1:0] rdy, input int ptr);
    for (int i = 0; i < NUM_PE; i++) begin
      if (rdy[(ptr + i) % NUM_PE]) return (ptr + i) % NUM_PE;
    end
    return ptr;
  endfunction

  function automatic logic [NUM_PE_LOG2-1:0] pe_of(input logic [NUM_PE-1:0] v);
    pe_of = '0;
    for (int i = NUM_PE-1; i >= 0; i--) begin
      if (v[i]) pe_of = NUM_PE_LOG2'(i);
    end
  endfunction

  // Drives one row, pushes its expected jobs, returns cycles spent waiting for row_ready.
  task automatic send_row(input logic [ADDR_WIDTH-1:0] head, input logic [3:0] hv,
                          input logic dl, output int waited);
    int tgt;
    row_head_addr          = head;
    row_history_valid      = hv;
    row_delim              = dl;
    row_history_addr       = {$urandom(), $urandom()};
    row_meta_match_len     = (HASH_ISSUE_WIDTH*META_MATCH_LEN_WIDTH)'($urandom());
    row_meta_match_can_ext = HASH_ISSUE_WIDTH'($urandom());
    row_data               = $urandom();
    for (int s = 0; s < HASH_ISSUE_WIDTH; s++) begin
      if (hv[s]) begin
        tgt = model_pick(job_ready, model_rr);
        model_rr = (tgt + 1) % NUM_PE;
        exp_q.push_back({NUM_PE_LOG2'(tgt), head + ADDR_WIDTH'(s),
                         row_history_addr[s*ADDR_WIDTH +: ADDR_WIDTH],
                         row_meta_match_len[s*META_MATCH_LEN_WIDTH +: META_MATCH_LEN_WIDTH],
                         row_meta_match_can_ext[s], row_data[s*8 +: 8]});
      end
    end
    row_valid = 1'b1;
    waited = 0;
    while (row_ready !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) begin
      checks++;
      errors++;
      $display("FAIL row_accept_timeout: row_ready=%b after %0d cycles, required 1", row_ready, waited);
    end
    tick();
    row_valid = 1'b0;
  endtask

  task automatic wait_jobs_drained(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d jobs outstanding, required 0", name, exp_q.size());
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (job_valid & job_ready) != '0) begin
      mon_obs = {pe_of(job_valid), job_head_addr, job_history_addr, job_meta_match_len,
                 job_meta_match_can_ext, job_data};
      checks++;
      if ($countones(job_valid) != 1) begin
        errors++;
        $display("FAIL job_onehot: job_valid=%b, required exactly one bit", job_valid);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL job_unexpected: got %h, required no job", mon_obs);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_obs !== mon_exp) begin
          errors++;
          $display("FAIL job_payload: got %h, required %h", mon_obs, mon_exp);
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    row_valid = 1'b0;
    row_head_addr = '0;
    row_history_valid = '0;
    row_history_addr = '0;
    row_meta_match_len = '0;
    row_meta_match_can_ext = '0;
    row_data = '0;
    row_delim = 1'b0;
    job_ready = '1;
    pe_idle = '1;
    done_ready = 1'b0;
    tick();
    tick();
    checks++;
    if ({row_ready, job_valid, done_valid, job_head_addr, job_data, dbg_state} !==
        {1'b0, 4'b0000, 1'b0, 16'd0, 8'd0, DISP_S_IDLE}) begin
      errors++;
      $display("FAIL reset_values: rr=%b jv=%b dv=%b ha=%h d=%h st=%0d, required all zero/IDLE",
               row_ready, job_valid, done_valid, job_head_addr, job_data, dbg_state);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({row_ready, job_valid, dbg_state} !== {1'b1, 4'b0000, DISP_S_IDLE}) begin
      errors++;
      $display("FAIL reset_release: rr=%b jv=%b st=%0d, required 1/0000/IDLE", row_ready, job_valid, dbg_state);
    end
  endtask

  task automatic test_basic();
    int w;
    job_ready = '1;
    pe_idle = '1;
    send_row(16'd100, 4'b1011, 1'b0, w);
    checks++;
    if ({row_ready, job_valid, job_head_addr} !== {1'b0, 4'b0001, 16'd100}) begin
      errors++;
      $display("FAIL basic_job0: rr=%b jv=%b ha=%0d, required 0/0001/100", row_ready, job_valid, job_head_addr);
    end
    tick();
    checks++;
    if ({job_valid, job_head_addr} !== {4'b0010, 16'd101}) begin
      errors++;
      $display("FAIL basic_job1: jv=%b ha=%0d, required 0010/101", job_valid, job_head_addr);
    end
    tick();
    checks++;
    if ({job_valid, job_head_addr} !== {4'b0100, 16'd103}) begin
      errors++;
      $display("FAIL basic_job2: jv=%b ha=%0d, required 0100/103", job_valid, job_head_addr);
    end
    tick();
    checks++;
    if ({row_ready, job_valid} !== {1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL basic_ready_cycle4: rr=%b jv=%b, required 1/0000", row_ready, job_valid);
    end
    wait_jobs_drained("basic");
  endtask

  task automatic test_empty_row();
    int w;
    send_row(16'd7, 4'b0000, 1'b0, w);
    checks++;
    if ({row_ready, job_valid} !== {1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL empty_consumed: rr=%b jv=%b, required 1/0000", row_ready, job_valid);
    end
    send_row(16'd8, 4'b0000, 1'b0, w);
    checks++;
    if (w !== 0) begin
      errors++;
      $display("FAIL empty_next_accept: waited %0d cycles, required 0", w);
    end
  endtask

  task automatic test_drain();
    int w;
    int n;
    pe_idle = 4'b1011;
    send_row(16'h0040, 4'b0001, 1'b1, w);
    checks++;
    if (job_valid !== 4'b1000) begin
      errors++;
      $display("FAIL drain_job: jv=%b, required 1000", job_valid);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (done_valid !== 1'b0) begin
        errors++;
        $display("FAIL drain_early_done: cycle %0d done_valid=%b, required 0", i, done_valid);
      end
    end
    pe_idle = '1;
    done_ready = 1'b1;
    n = 0;
    while (done_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (done_valid !== 1'b1) begin
      errors++;
      $display("FAIL drain_done_timeout: done_valid=%b after %0d cycles, required 1", done_valid, n);
    end
    tick();
    checks++;
    if ({done_valid, row_ready} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL drain_done_pulse: dv=%b rr=%b, required 0/1", done_valid, row_ready);
    end
    done_ready = 1'b0;
    wait_jobs_drained("drain");
  endtask

  task automatic test_target_stall();
    int w;
    job_ready = 4'b0100;
    send_row(16'd200, 4'b0001, 1'b0, w);
    checks++;
    if (job_valid !== 4'b0100) begin
      errors++;
      $display("FAIL stall_first_ready: jv=%b, required 0100", job_valid);
    end
    tick();
    job_ready = 4'b0000;
    send_row(16'd300, 4'b0010, 1'b0, w);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({job_valid, job_head_addr, job_history_addr, job_meta_match_len, job_meta_match_can_ext,
           job_data} !== {4'b1000, exp_q[0][JOB_W-1:0]}) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d jv=%b ha=%0d, required 1000 with payload %h",
                 i, job_valid, job_head_addr, exp_q[0][JOB_W-1:0]);
      end
      tick();
    end
    job_ready = 4'b1000;
    tick();
    job_ready = '1;
    wait_jobs_drained("stall");
  endtask

  task automatic test_wrap();
    int w;
    send_row(16'hFFFF, 4'b0010, 1'b0, w);
    checks++;
    if ({job_valid, job_head_addr} !== {4'b0001, 16'd0}) begin
      errors++;
      $display("FAIL wrap_head: jv=%b ha=%h, required 0001/0000", job_valid, job_head_addr);
    end
    wait_jobs_drained("wrap");
  endtask

  task automatic test_back_to_back();
    int w;
    send_row(16'h1000, 4'b1111, 1'b0, w);
    send_row(16'h2000, 4'b1111, 1'b0, w);
    checks++;
    if (w !== 4) begin
      errors++;
      $display("FAIL full_row_throughput: waited %0d cycles, required 4", w);
    end
    for (int i = 0; i < 10; i++) begin
      send_row(ADDR_WIDTH'($urandom()), 4'($urandom_range(0, 15)), 1'b0, w);
    end
    wait_jobs_drained("back_to_back");
  endtask

  task automatic test_reset_mid();
    int w;
    job_ready = '0;
    send_row(16'h0500, 4'b1111, 1'b0, w);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({job_valid, row_ready, done_valid, job_head_addr, dbg_state} !==
        {4'b0000, 1'b0, 1'b0, 16'd0, DISP_S_IDLE}) begin
      errors++;
      $display("FAIL reset_mid_async: jv=%b rr=%b dv=%b ha=%h st=%0d, required zeros/IDLE",
               job_valid, row_ready, done_valid, job_head_addr, dbg_state);
    end
    exp_q.delete();
    model_rr = 0;
    job_ready = '1;
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({row_ready, dbg_state} !== {1'b1, DISP_S_IDLE}) begin
      errors++;
      $display("FAIL reset_mid_release: rr=%b st=%0d, required 1/IDLE", row_ready, dbg_state);
    end
    send_row(16'h0600, 4'b0011, 1'b0, w);
    checks++;
    if (job_valid !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid_rr_ptr: jv=%b, required 0001", job_valid);
    end
    wait_jobs_drained("reset_mid");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_empty_row();
    test_drain();
    test_target_stall();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: %0d expected jobs never seen, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
